// File: rtl/decode_stage.sv
// decode_stage: RV32 instruction decoder followed by a DEPTH-entry output queue.
// Each accepted instruction is decoded combinationally and stored as one record;
// the head record drives out_* (all zero while the queue is empty).
// Optional macro DECODE_RV32M_EN: accept OP with funct7=0000001 as mul/div.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [5:0]      out_op,
  output logic            out_alt,
  output logic            out_rs1_v,
  output logic            out_rs2_v,
  output logic            out_imm_v,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_muldiv,
  output logic            out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [5:0]      op;
    logic            alt;
    logic            rs1_v;
    logic            rs2_v;
    logic            imm_v;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            muldiv;
    logic            illegal;
  } rec_t;

  // Immediate extraction, one function per encoding format.
  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  logic [2:0]             cls_p0;
  logic [2:0]             fn_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   rs1v_p0, rs2v_p0, immv_p0, alt_p0, md_p0, rdz_p0, legal_p0;
  rec_t                   dec_p0;

  rec_t                   mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count;
  logic                   vld_p1, push, pop;
  rec_t                   head_p1;

  // ---- stage p0: combinational decode of the incoming instruction ----
  // Classify the opcode, pick the immediate format and operand-valid flags.
  always_comb begin
    cls_p0   = 3'd0;
    fn_p0    = in_instr[14:12];
    imm_p0   = '0;
    rs1v_p0  = 1'b0;
    rs2v_p0  = 1'b0;
    immv_p0  = 1'b0;
    alt_p0   = 1'b0;
    md_p0    = 1'b0;
    rdz_p0   = 1'b0;
    legal_p0 = (in_instr[1:0] == 2'b11);
    case (in_instr[6:2])
      5'b00000: begin cls_p0 = 3'd0; imm_p0 = imm_i(in_instr); rs1v_p0 = 1'b1; immv_p0 = 1'b1; end
      5'b01000: begin
        cls_p0 = 3'd1; imm_p0 = imm_s(in_instr);
        rs1v_p0 = 1'b1; rs2v_p0 = 1'b1; immv_p0 = 1'b1; rdz_p0 = 1'b1;
      end
      5'b11000: begin
        cls_p0 = 3'd2; imm_p0 = imm_b(in_instr);
        rs1v_p0 = 1'b1; rs2v_p0 = 1'b1; immv_p0 = 1'b1; rdz_p0 = 1'b1;
      end
      5'b11011: begin cls_p0 = 3'd3; fn_p0 = 3'b000; imm_p0 = imm_j(in_instr); immv_p0 = 1'b1; end
      5'b11001: begin cls_p0 = 3'd3; imm_p0 = imm_i(in_instr); rs1v_p0 = 1'b1; immv_p0 = 1'b1; end
      5'b00100: begin
        cls_p0 = 3'd4; imm_p0 = imm_i(in_instr); rs1v_p0 = 1'b1; immv_p0 = 1'b1;
        // shift-immediate carries its arithmetic/logical select in bit 30
        alt_p0 = (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) ? in_instr[30] : 1'b0;
      end
      5'b01100: begin
        cls_p0 = 3'd5; rs1v_p0 = 1'b1; rs2v_p0 = 1'b1; alt_p0 = in_instr[30];
        case (in_instr[31:25])
          7'b0000000, 7'b0100000: ;
`ifdef DECODE_RV32M_EN
          7'b0000001: md_p0 = 1'b1;
`endif
          default: legal_p0 = 1'b0;
        endcase
      end
      5'b01101: begin cls_p0 = 3'd6; fn_p0 = 3'b000; imm_p0 = imm_u(in_instr); immv_p0 = 1'b1; end
      5'b00101: begin cls_p0 = 3'd6; fn_p0 = 3'b001; imm_p0 = imm_u(in_instr); immv_p0 = 1'b1; end
      5'b11100: begin cls_p0 = 3'd7; imm_p0 = imm_i(in_instr); rs1v_p0 = 1'b1; immv_p0 = 1'b1; end
      default:  legal_p0 = 1'b0;
    endcase
  end

  // Pack the decode into a queue record; illegal instructions keep only pc and the flag.
  always_comb begin
    dec_p0         = '0;
    dec_p0.pc      = in_pc;
    dec_p0.illegal = ~legal_p0;
    if (legal_p0) begin
      dec_p0.op     = {cls_p0, fn_p0};
      dec_p0.alt    = alt_p0;
      dec_p0.rs1_v  = rs1v_p0;
      dec_p0.rs2_v  = rs2v_p0;
      dec_p0.imm_v  = immv_p0;
      dec_p0.rs1    = in_instr[19:15];
      dec_p0.rs2    = in_instr[24:20];
      dec_p0.rd     = rdz_p0 ? 5'd0 : in_instr[11:7];
      dec_p0.imm    = immv_p0 ? imm_p0 : '0;
      dec_p0.muldiv = md_p0;
    end
  end

  // in_ready depends only on occupancy and reset, never on out_ready.
  assign vld_p1   = (count != '0);
  assign in_ready = rst_n & (count < FULL_CNT);
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = vld_p1 & out_ready & ~flush;

  // ---- stage p1: output queue ----
  // Queue control: pointers wrap at DEPTH; flush empties the queue ahead of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Record storage, cleared on reset so nothing stale survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= dec_p0;
    end
  end

  assign head_p1     = vld_p1 ? mem[rd_ptr] : '0;
  assign out_valid   = vld_p1;
  assign out_pc      = head_p1.pc;
  assign out_op      = head_p1.op;
  assign out_alt     = head_p1.alt;
  assign out_rs1_v   = head_p1.rs1_v;
  assign out_rs2_v   = head_p1.rs2_v;
  assign out_imm_v   = head_p1.imm_v;
  assign out_rs1     = head_p1.rs1;
  assign out_rs2     = head_p1.rs2;
  assign out_rd      = head_p1.rd;
  assign out_imm     = head_p1.imm;
  assign out_muldiv  = head_p1.muldiv;
  assign out_illegal = head_p1.illegal;

endmodule
